// File: rtl/row_stat_upd_if.sv
// rtl/row_stat_upd_if.sv - score-column stream and statistics handshake for row_stat_upd
interface row_stat_upd_if #(
    parameter int D_W = 8,
    parameter int TIL = 16
);
    logic                           start;
    logic                           s_tvalid;
    logic                           s_tready;
    logic [0:TIL-1][D_W-1:0]        s_tdata;
    logic                           vld;
    logic                           ack;
    logic [0:TIL-1][2*D_W-1:0]      li_old;
    logic [0:TIL-1][D_W-1:0]        mi_old;
    logic [0:TIL-1][2*D_W-1:0]      li_new;
    logic [0:TIL-1][D_W-1:0]        mi_new;

    modport master (
        output start, s_tvalid, s_tdata, ack,
        input  s_tready, vld, li_old, mi_old, li_new, mi_new
    );

    modport slave (
        input  start, s_tvalid, s_tdata, ack,
        output s_tready, vld, li_old, mi_old, li_new, mi_new
    );
endinterface

// File: rtl/row_stat_upd.sv
// rtl/row_stat_upd.sv - online-softmax running row max / row sum tracker for one score tile
module row_stat_exp (
    input  logic signed [7:0] d,
    output logic        [7:0] e
);
    // e = round(32 * exp(d/32)); THR[i] is the smallest d that yields i+2.
    localparam logic signed [7:0] THR [31] = '{
        -8'sd97, -8'sd81, -8'sd70, -8'sd62, -8'sd56, -8'sd51, -8'sd46, -8'sd42,
        -8'sd38, -8'sd35, -8'sd32, -8'sd30, -8'sd27, -8'sd25, -8'sd23, -8'sd21,
        -8'sd19, -8'sd17, -8'sd15, -8'sd14, -8'sd12, -8'sd11, -8'sd9,  -8'sd8,
        -8'sd7,  -8'sd6,  -8'sd4,  -8'sd3,  -8'sd2,  -8'sd1,  8'sd0
    };

    always_comb begin
        e = 8'd1;
        for (int i = 0; i < 31; i++) begin
            if (d >= THR[i]) begin
                e = e + 8'd1;
            end
        end
    end
endmodule

module row_stat_upd #(
    parameter int D_W = 8,
    parameter int TIL = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    row_stat_upd_if.slave bus
);
    localparam int CW    = $clog2(TIL);
    localparam int ACC_W = 2 * D_W + 1;
    localparam int FRAC  = D_W - 3;
    localparam int PRD_W = 3 * D_W;
    localparam int SUM_W = 2 * D_W + 4;
    localparam logic signed [D_W-1:0] M_INIT = {1'b1, {(D_W-1){1'b0}}};
    localparam logic signed [D_W:0]   D_MIN  = {2'b11, {(D_W-1){1'b0}}};
    localparam logic signed [D_W:0]   D_MAX  = {2'b00, {(D_W-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, LOAD, SUM, FIN, OUT} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             col_q;
    logic [D_W-1:0]            tile_buf [TIL][TIL];
    logic signed [D_W-1:0]     m_old    [TIL];
    logic signed [D_W-1:0]     m_run    [TIL];
    logic [2*D_W-1:0]          l_old    [TIL];
    logic [ACC_W-1:0]          acc      [TIL];
    logic signed [D_W-1:0]     exp_in   [TIL];
    logic [D_W-1:0]            exp_out  [TIL];
    logic [PRD_W-1:0]          prod     [TIL];
    logic [SUM_W-1:0]          lsum     [TIL];
    logic [2*D_W-1:0]          l_calc   [TIL];
    logic [0:TIL-1][2*D_W-1:0] li_old_q, li_new_q;
    logic [0:TIL-1][D_W-1:0]   mi_old_q, mi_new_q;
    logic                      last_col;
    logic                      load_beat;

    function automatic logic signed [D_W-1:0] sat_diff(input logic signed [D_W-1:0] a,
                                                       input logic signed [D_W-1:0] b);
        logic signed [D_W:0] t;
        t = $signed({a[D_W-1], a}) - $signed({b[D_W-1], b});
        if (t < D_MIN) begin
            return M_INIT;
        end else if (t > D_MAX) begin
            return {1'b0, {(D_W-1){1'b1}}};
        end
        return t[D_W-1:0];
    endfunction

    assign last_col  = (col_q == CW'(TIL - 1));
    assign load_beat = (state_q == LOAD) && bus.s_tvalid && !bus.start;

    // The same exponent units serve the per-element terms in SUM and the row scale in FIN.
    for (genvar r = 0; r < TIL; r++) begin : g_exp
        row_stat_exp u_exp (
            .d (exp_in[r]),
            .e (exp_out[r])
        );
    end

    always_comb begin
        for (int r = 0; r < TIL; r++) begin
            exp_in[r] = (state_q == FIN) ? sat_diff(m_old[r], m_run[r])
                                         : sat_diff($signed(tile_buf[r][col_q]), m_run[r]);
            prod[r]   = {{(2*D_W){1'b0}}, exp_out[r]} * {{D_W{1'b0}}, l_old[r]};
            lsum[r]   = {1'b0, prod[r][PRD_W-1:FRAC]} + {{(SUM_W-ACC_W){1'b0}}, acc[r]};
            l_calc[r] = (|lsum[r][SUM_W-1:2*D_W]) ? {(2*D_W){1'b1}} : lsum[r][2*D_W-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.s_tready = 1'b0;
        bus.vld      = 1'b0;
        case (state_q)
            IDLE: ;
            LOAD: begin
                bus.s_tready = 1'b1;
                if (bus.s_tvalid && last_col) state_d = SUM;
            end
            SUM:  if (last_col) state_d = FIN;
            FIN:  state_d = OUT;
            OUT: begin
                bus.vld = 1'b1;
                if (bus.ack) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
        if (bus.start) state_d = LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_beat) begin
            for (int r = 0; r < TIL; r++) tile_buf[r][col_q] <= bus.s_tdata[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            li_old_q <= '0;
            li_new_q <= '0;
            mi_old_q <= '0;
            mi_new_q <= '0;
            for (int r = 0; r < TIL; r++) begin
                m_old[r] <= '0;
                m_run[r] <= '0;
                l_old[r] <= '0;
                acc[r]   <= '0;
            end
        end else if (bus.start) begin
            col_q <= '0;
            for (int r = 0; r < TIL; r++) begin
                m_old[r] <= M_INIT;
                m_run[r] <= M_INIT;
                l_old[r] <= '0;
                acc[r]   <= '0;
            end
        end else begin
            case (state_q)
                LOAD: if (bus.s_tvalid) begin
                    col_q <= last_col ? '0 : col_q + 1'b1;
                    for (int r = 0; r < TIL; r++) begin
                        if ($signed(bus.s_tdata[r]) > m_run[r]) m_run[r] <= $signed(bus.s_tdata[r]);
                    end
                end
                SUM: begin
                    col_q <= last_col ? '0 : col_q + 1'b1;
                    for (int r = 0; r < TIL; r++) begin
                        acc[r] <= acc[r] + {{(ACC_W-D_W-3){1'b0}}, exp_out[r], 3'b000};
                    end
                end
                FIN: begin
                    for (int r = 0; r < TIL; r++) begin
                        li_old_q[r] <= l_old[r];
                        mi_old_q[r] <= m_old[r];
                        li_new_q[r] <= l_calc[r];
                        mi_new_q[r] <= m_run[r];
                        acc[r]      <= '0;
                    end
                end
                OUT: if (bus.ack) begin
                    for (int r = 0; r < TIL; r++) begin
                        m_old[r] <= mi_new_q[r];
                        m_run[r] <= mi_new_q[r];
                        l_old[r] <= li_new_q[r];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.li_old = li_old_q;
    assign bus.mi_old = mi_old_q;
    assign bus.li_new = li_new_q;
    assign bus.mi_new = mi_new_q;
endmodule

// File: doc/row_stat_upd.md
Name: row_stat_upd

Overview:
- Online-softmax row-statistics tracker for tiled attention.
- Buffers one TIL x TIL score tile S (Q2.5 signed), which arrives one column per beat.
- Computes the new running row max m_new and running row sum l_new from the held m_old and l_old.
- Presents (l_old, m_old, l_new, m_new) as one stable set to the downstream output-matrix coefficient stage, and holds it until that stage acknowledges.

Parameters:
- D_W, 8, score and max width (signed Q2.5).
- TIL, 16, rows per tile and columns per tile.

Ports:
- I_CLK  in  1  clock
- I_RST_N  in  1  asynchronous active-low reset
- I_START  in  1  one-cycle pulse; starts a new row sequence (m_old=0x80, l_old=0)
- I_S_VLD  in  1  score column valid
- O_S_RDY  out  1  score column ready
- I_S_COL  in  D_W x [0:TIL-1]  one column: element r is S[r][c]
- O_VLD  out  1  statistics valid; also drives downstream enable (must be held)
- I_ACK  in  1  downstream done (its valid); commits the statistics
- O_LI_OLD  out  2*D_W x [0:TIL-1]  previous row sum, unsigned Q8.8
- O_MI_OLD  out  D_W x [0:TIL-1]  previous row max, Q2.5
- O_LI_NEW  out  2*D_W x [0:TIL-1]  updated row sum, unsigned Q8.8
- O_MI_NEW  out  D_W x [0:TIL-1]  updated row max, Q2.5

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; m_old=0, l_old=0; column counter=0; tile buffer need not be cleared.
- States: IDLE, LOAD, SUM, FIN, OUT.
- IDLE:
  - O_S_RDY=0.
  - I_START -> m_old[r]=0x80 and l_old[r]=0 for all r; m_run[r]=0x80; go to LOAD.
- LOAD:
  - O_S_RDY=1.
  - Each beat with I_S_VLD&O_S_RDY: write the column into buffer[*][col]; m_run[r]=signed max(m_run[r], I_S_COL[r]); col++.
  - On the beat with col==TIL-1: col=0, go to SUM.
  - Gaps in I_S_VLD stall LOAD with no state change.
- SUM:
  - Exactly TIL cycles, one buffered column per cycle.
  - Per element: d = sat8(S[r][c] - m_run[r]), computed at 9 bits and clamped to >= -128 (d is never > 0).
  - e = Exp_x(d), 8-bit Q2.5.
  - acc[r] += e << 3 (Q8.8), acc width 2*D_W+1.
  - Use TIL Exp_x instances.
- FIN:
  - One cycle.
  - Row scale: g[r] = Exp_x(sat8(m_old[r] - m_run[r])).
  - l_new[r] = sat16((g[r] * l_old[r]) >> 5 + acc[r]). The product is 24 bits; saturate to 0xFFFF on overflow.
  - m_new[r] = m_run[r].
  - Latch all four output arrays.
  - Go to OUT; acc is cleared.
- OUT:
  - O_VLD=1, with all O_* arrays held constant.
  - On I_ACK: m_old=m_new, l_old=l_new; m_run=m_new (it seeds the next tile); O_VLD=0 in the next cycle; go to LOAD.
- Latency: last column accepted at cycle t -> SUM on cycles t+1..t+TIL, FIN on t+TIL+1, O_VLD=1 from t+TIL+2.
- I_START while not in IDLE:
  - Synchronous abort: clear acc and col, reinitialise m_old, l_old and m_run, drop O_VLD, go to LOAD.
  - I_START has priority over a simultaneous I_ACK or load beat; the load beat is discarded.
- I_ACK outside OUT is ignored.
- Reset mid-operation returns to IDLE immediately; a partial tile is lost.
- First tile: g = Exp_x(0x80), which is approximately 0, and l_old=0, so l_new = acc.
- Signed max treats 0x80 as -4.0, the most negative value.

Test Plan:
- Reset, I_START, then one tile of all 0x00 scores -> O_MI_NEW=0x00 and O_LI_NEW=0x1000 on every row; O_MI_OLD=0x80, O_LI_OLD=0; O_VLD asserted exactly TIL+2 cycles after the last beat.
- Ack, then a second tile of all 0x20 -> O_MI_OLD=0x00, O_LI_OLD=0x1000, O_MI_NEW=0x20. Let E=Exp_x(0xE0): O_LI_NEW = (E*0x1000>>5) + 0x1000, which is 0x1600 for E=12.
- Row 3 only gets one element of 0x7F and all other elements 0x80 -> m_new[3]=0x7F; its sum includes Exp_x(0x80) terms for the 0x80 elements (differences clamped to -128); other rows are unaffected.
- Sixteen consecutive all-zero tiles, each acked -> l grows by 0x1000 per tile and saturates to 0xFFFF on tile 16; no wrap.
- Random I_S_VLD gaps plus I_ACK withheld for 20 cycles -> results equal to the gap-free run; O_* arrays and O_VLD stable throughout the hold; O_S_RDY=0 outside LOAD.
- I_START during SUM, then during OUT together with I_ACK -> abort, O_VLD=0 next cycle, next tile computed from m_old=0x80 and l_old=0; async reset during OUT -> all outputs 0 immediately.
